// File: rtl/kernel_raster_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : kernel_raster_scanner
//  Function : Raster-order (row, column) coordinate generator with border flags
//             and a valid/ready handshake, for the kernel neighbour-address stage.
//  Revision : 1.0 - initial release
// ============================================================================
module kernel_raster_scanner #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] frame_width,
    input  logic [ADDR_W-1:0] frame_depth,
    output logic [ADDR_W-1:0] address_width,
    output logic [ADDR_W-1:0] address_depth,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              first_pix,
    output logic              last_pix,
    output logic              border_left,
    output logic              border_right,
    output logic              border_top,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] c_one = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_w_m1;
    logic [ADDR_W-1:0] r_d_m1;
    logic [ADDR_W-1:0] r_col;
    logic [ADDR_W-1:0] r_row;
    logic              r_first;
    logic              r_last;
    logic              r_bl;
    logic              r_br;
    logic              r_bt;

    logic              w_load;
    logic              w_xfer;
    logic              w_advance;
    logic [ADDR_W-1:0] w_wm1_nxt;
    logic [ADDR_W-1:0] w_dm1_nxt;
    logic [ADDR_W-1:0] w_col_nxt;
    logic [ADDR_W-1:0] w_row_nxt;

    assign w_xfer    = (r_state == ST_SCAN) && out_ready;
    assign w_advance = w_load || (w_xfer && !r_last);

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if ((frame_width != '0) && (frame_depth != '0)) begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_SCAN;
                    end else begin
                        w_state_nxt = ST_FINISH;
                    end
                end
            end
            ST_SCAN: begin
                if (w_xfer && r_last) begin
                    w_state_nxt = ST_FINISH;
                end
            end
            ST_FINISH: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Next coordinate; r_br already tells us the current column is W-1.
    always_comb begin
        w_wm1_nxt = w_load ? (frame_width - c_one) : r_w_m1;
        w_dm1_nxt = w_load ? (frame_depth - c_one) : r_d_m1;
        if (w_load) begin
            w_col_nxt = '0;
            w_row_nxt = '0;
        end else if (r_br) begin
            w_col_nxt = '0;
            w_row_nxt = r_row + c_one;
        end else begin
            w_col_nxt = r_col + c_one;
            w_row_nxt = r_row;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_w_m1  <= '0;
            r_d_m1  <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
            r_bl    <= 1'b0;
            r_br    <= 1'b0;
            r_bt    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_w_m1 <= w_wm1_nxt;
                r_d_m1 <= w_dm1_nxt;
            end
            if (w_advance) begin
                r_col   <= w_col_nxt;
                r_row   <= w_row_nxt;
                r_first <= (w_col_nxt == '0) && (w_row_nxt == '0);
                r_last  <= (w_col_nxt == w_wm1_nxt) && (w_row_nxt == w_dm1_nxt);
                r_bl    <= (w_col_nxt == '0);
                r_br    <= (w_col_nxt == w_wm1_nxt);
                r_bt    <= (w_row_nxt == '0);
            end
        end
    end

    // Flags are only meaningful alongside a valid pair, so they are gated.
    assign out_valid     = (r_state == ST_SCAN);
    assign busy          = (r_state == ST_SCAN);
    assign done          = (r_state == ST_FINISH);
    assign address_width = r_col;
    assign address_depth = r_row;
    assign first_pix     = r_first & out_valid;
    assign last_pix      = r_last  & out_valid;
    assign border_left   = r_bl    & out_valid;
    assign border_right  = r_br    & out_valid;
    assign border_top    = r_bt    & out_valid;

endmodule
`default_nettype wire

// File: tb/tb_kernel_raster_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_kernel_raster_scanner
//  Function : Self-checking bench for kernel_raster_scanner against a raster
//             reference model built from nested row/column loops.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_kernel_raster_scanner;

    localparam int AW = 10;
    typedef logic [2*AW+4:0] beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] frame_width;
    logic [AW-1:0] frame_depth;
    logic [AW-1:0] address_width;
    logic [AW-1:0] address_depth;
    logic          out_valid;
    logic          out_ready;
    logic          first_pix;
    logic          last_pix;
    logic          border_left;
    logic          border_right;
    logic          border_top;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_errors = 0;

    kernel_raster_scanner #(.ADDR_W(AW)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .frame_width   (frame_width),
        .frame_depth   (frame_depth),
        .address_width (address_width),
        .address_depth (address_depth),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .first_pix     (first_pix),
        .last_pix      (last_pix),
        .border_left   (border_left),
        .border_right  (border_right),
        .border_top    (border_top),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    // {col, row, first, last, left, right, top}
    function automatic beat_t expect_beat(input int c, input int r, input int w, input int d);
        return {AW'(c), AW'(r), (c == 0 && r == 0), (c == w-1 && r == d-1),
                (c == 0), (c == w-1), (r == 0)};
    endfunction

    function automatic beat_t observed();
        return {address_width, address_depth, first_pix, last_pix,
                border_left, border_right, border_top};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        frame_width = '0; frame_depth = '0;
        cyc(); cyc();
        n_checks++;
        if (observed() !== '0 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: got beat=%h v=%b b=%b d=%b, want all zero",
                     observed(), out_valid, busy, done);
        end
        rst = 1'b0;
        cyc();
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_after_reset: got v=%b b=%b d=%b, want 0 0 0",
                     out_valid, busy, done);
        end
    endtask

    // Full frame scan with random backpressure; poke re-pulses start mid-scan.
    task automatic test_frame(input int w, input int d, input int pct, input bit poke);
        beat_t q[$];
        int    cycles;
        int    budget;
        bit    xfer;
        for (int r = 0; r < d; r++)
            for (int c = 0; c < w; c++)
                q.push_back(expect_beat(c, r, w, d));
        frame_width = AW'(w); frame_depth = AW'(d); start = 1'b1;
        cyc();
        start = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL start_latency %0dx%0d: got v=%b b=%b, want 1 1", w, d, out_valid, busy);
        end
        cycles = 0;
        budget = w * d * 20 + 50;
        while (q.size() > 0 && cycles < budget) begin
            out_ready   = ($urandom_range(0, 99) < pct);
            frame_width = AW'($urandom);
            frame_depth = AW'($urandom);
            start       = poke && (cycles == 2);
            n_checks++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || observed() !== q[0]) begin
                n_errors++;
                $display("FAIL beat %0dx%0d idx=%0d: got v=%b b=%b d=%b beat=%h, want v=1 b=1 d=0 beat=%h",
                         w, d, w*d - q.size(), out_valid, busy, done, observed(), q[0]);
            end
            xfer = out_ready;
            cyc();
            if (xfer) void'(q.pop_front());
            cycles++;
        end
        start = 1'b0;
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL scan_timeout %0dx%0d: got %0d beats left, want 0", w, d, q.size());
        end
        n_checks++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            {first_pix, last_pix, border_left, border_right, border_top} !== 5'b0) begin
            n_errors++;
            $display("FAIL done_pulse %0dx%0d: got d=%b v=%b b=%b flags=%b, want d=1 v=0 b=0 flags=0",
                     w, d, done, out_valid, busy,
                     {first_pix, last_pix, border_left, border_right, border_top});
        end
        if (pct >= 100) begin
            n_checks++;
            if (cycles != w * d) begin
                n_errors++;
                $display("FAIL throughput %0dx%0d: got %0d cycles, want %0d", w, d, cycles, w*d);
            end
        end
        cyc();
        n_checks++;
        if (done !== 1'b0 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL done_single %0dx%0d: got d=%b v=%b, want 0 0", w, d, done, out_valid);
        end
    endtask

    task automatic test_empty_frame(input int w, input int d);
        int pulses = 0;
        frame_width = AW'(w); frame_depth = AW'(d); start = 1'b1; out_ready = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (done === 1'b1) pulses++;
            n_checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                n_errors++;
                $display("FAIL empty_frame %0dx%0d cyc=%0d: got v=%b b=%b, want 0 0",
                         w, d, i, out_valid, busy);
            end
            cyc();
        end
        n_checks++;
        if (pulses != 1) begin
            n_errors++;
            $display("FAIL empty_done %0dx%0d: got %0d done pulses, want 1", w, d, pulses);
        end
    endtask

    task automatic test_abort();
        frame_width = AW'(8); frame_depth = AW'(8); start = 1'b1; out_ready = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || observed() !== expect_beat(i, 0, 8, 8)) begin
                n_errors++;
                $display("FAIL abort_beat %0d: got v=%b beat=%h, want v=1 beat=%h",
                         i, out_valid, observed(), expect_beat(i, 0, 8, 8));
            end
            cyc();
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                n_errors++;
                $display("FAIL abort_idle cyc=%0d: got v=%b b=%b d=%b, want 0 0 0",
                         i, out_valid, busy, done);
            end
            cyc();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_frame(3, 2, 100, 1'b0);
        test_frame(4, 4, 50, 1'b0);
        test_frame(1, 1, 100, 1'b0);
        test_frame(1, 3, 70, 1'b0);
        test_frame(4, 1, 70, 1'b0);
        test_empty_frame(0, 5);
        test_empty_frame(6, 0);
        test_abort();
        test_frame(2, 2, 100, 1'b0);
        test_frame(5, 3, 60, 1'b1);
        for (int k = 0; k < 4; k++)
            test_frame($urandom_range(1, 7), $urandom_range(1, 6), $urandom_range(30, 100), 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
